// File: rtl/arm_main_fsm.sv
// Main sequencing FSM of the multicycle ARM core: walks the shared datapath through
// fetch/decode/execute/memory/writeback and stalls on the memory-ready handshake.
module arm_main_fsm #(
    parameter int STATE_W = 4,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ALUOp,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic [STATE_W-1:0] State
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_ready;

    // With the handshake disabled every access completes in one cycle.
    assign mem_ready = WAIT_EN ? MemReady : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b0;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        if (reset) begin
            // Strobes stay low; selects present the fetch datapath.
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    NextPC    = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_MEMADR: begin
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                S_EXECUTER: begin
                    ALUOp = 1'b1;
                end
                S_EXECUTEI: begin
                    ALUSrcB = 2'b01;
                    ALUOp   = 1'b1;
                end
                S_ALUWB: begin
                    RegW = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_arm_main_fsm.sv
// Directed table-driven bench for arm_main_fsm plus hand-written stall/reset sequences.
module tb_arm_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arm_main_fsm #(.STATE_W(4), .WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .State(State)
    );

    // Packed output word: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,NextPC,RegW,MemW,Branch}
    function automatic logic [12:0] o(logic ir, logic adr, logic [1:0] sa, logic [1:0] sb,
                                      logic aop, logic [1:0] rs, logic npc, logic rw,
                                      logic mw, logic br);
        return {ir, adr, sa, sb, aop, rs, npc, rw, mw, br};
    endfunction

    logic [12:0] act_out;
    assign act_out = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, NextPC, RegW, MemW, Branch};

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [12:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(logic r, logic [1:0] op, logic [5:0] f, logic rdy,
                       logic [3:0] st, logic [12:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.funct = f; v.rdy = rdy; v.exp_state = st; v.exp_out = out;
        vecs.push_back(v);
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [12:0] FR, FS, DEC, MA, MR, MWB, MWR, EXR, EXI, AWB, BR, RST;
        int cyc;
        int regw_seen;
        int memw_cycles;

        FR  = o(1, 0, 2'b01, 2'b10, 0, 2'b10, 1, 0, 0, 0);
        FS  = o(0, 0, 2'b01, 2'b10, 0, 2'b10, 0, 0, 0, 0);
        DEC = o(0, 0, 2'b01, 2'b10, 0, 2'b10, 0, 0, 0, 0);
        RST = o(0, 0, 2'b01, 2'b10, 0, 2'b10, 0, 0, 0, 0);
        MA  = o(0, 0, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0, 0);
        MR  = o(0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
        MWB = o(0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 1, 0, 0);
        MWR = o(0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 0);
        EXR = o(0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0);
        EXI = o(0, 0, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0, 0);
        AWB = o(0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 0);
        BR  = o(0, 0, 2'b00, 2'b01, 0, 2'b10, 0, 0, 0, 1);

        // reset held
        add(1, 2'b00, 6'b001000, 1, 4'd0, RST);
        // ADD reg
        add(0, 2'b00, 6'b001000, 1, 4'd0, FR);
        add(0, 2'b00, 6'b001000, 1, 4'd1, DEC);
        add(0, 2'b00, 6'b001000, 1, 4'd6, EXR);
        add(0, 2'b00, 6'b001000, 1, 4'd8, AWB);
        // SUB imm
        add(0, 2'b00, 6'b100100, 1, 4'd0, FR);
        add(0, 2'b00, 6'b100100, 1, 4'd1, DEC);
        add(0, 2'b00, 6'b100100, 1, 4'd7, EXI);
        add(0, 2'b11, 6'b000000, 1, 4'd8, AWB);   // Op ignored outside DECODE
        // LDR
        add(0, 2'b01, 6'b011001, 1, 4'd0, FR);
        add(0, 2'b01, 6'b011001, 1, 4'd1, DEC);
        add(0, 2'b01, 6'b011001, 1, 4'd2, MA);
        add(0, 2'b01, 6'b011001, 1, 4'd3, MR);
        add(0, 2'b01, 6'b011001, 1, 4'd4, MWB);
        // STR with two stall cycles
        add(0, 2'b01, 6'b011000, 1, 4'd0, FR);
        add(0, 2'b01, 6'b011000, 1, 4'd1, DEC);
        add(0, 2'b01, 6'b011000, 1, 4'd2, MA);
        add(0, 2'b01, 6'b011000, 0, 4'd5, MWR);
        add(0, 2'b01, 6'b011000, 0, 4'd5, MWR);
        add(0, 2'b01, 6'b011000, 1, 4'd5, MWR);
        // fetch stall then ADD
        add(0, 2'b00, 6'b001000, 0, 4'd0, FS);
        add(0, 2'b00, 6'b001000, 0, 4'd0, FS);
        add(0, 2'b00, 6'b001000, 0, 4'd0, FS);
        add(0, 2'b00, 6'b001000, 1, 4'd0, FR);
        add(0, 2'b00, 6'b001000, 1, 4'd1, DEC);
        add(0, 2'b00, 6'b001000, 0, 4'd6, EXR);   // MemReady ignored here
        add(0, 2'b00, 6'b001000, 1, 4'd8, AWB);
        // B
        add(0, 2'b10, 6'b000000, 1, 4'd0, FR);
        add(0, 2'b10, 6'b000000, 1, 4'd1, DEC);
        add(0, 2'b10, 6'b000000, 1, 4'd9, BR);
        // Op=11
        add(0, 2'b11, 6'b000000, 1, 4'd0, FR);
        add(0, 2'b11, 6'b000000, 1, 4'd1, DEC);
        // LDR interrupted by reset in MEMREAD
        add(0, 2'b01, 6'b011001, 1, 4'd0, FR);
        add(0, 2'b01, 6'b011001, 1, 4'd1, DEC);
        add(0, 2'b01, 6'b011001, 1, 4'd2, MA);
        add(1, 2'b01, 6'b011001, 1, 4'd3, RST);
        add(1, 2'b01, 6'b011001, 1, 4'd0, RST);
        add(0, 2'b11, 6'b000000, 1, 4'd0, FR);
        add(0, 2'b11, 6'b000000, 1, 4'd1, DEC);
        add(0, 2'b00, 6'b001000, 1, 4'd0, FR);

        reset = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b1;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; Op = vecs[i].op; Funct = vecs[i].funct; MemReady = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d state", i), int'(State), int'(vecs[i].exp_state));
            check($sformatf("vec%0d outputs", i), int'(act_out), int'(vecs[i].exp_out));
            $display("vec %0d: rst=%0b op=%0b funct=%b rdy=%0b state=%0d out=%h",
                     i, reset, Op, Funct, MemReady, State, act_out);
        end
        // After vec list: state is DECODE of an ADD at next edge.

        // Hand sequence 1: STR with a four-cycle stall counts MemW cycles.
        @(negedge clk);
        reset = 1'b1; MemReady = 1'b1;
        @(negedge clk);
        reset = 1'b0; Op = 2'b01; Funct = 6'b011000; MemReady = 1'b1;
        cyc = 0;
        while (State != 4'd5 && cyc < 10) begin
            @(negedge clk); cyc++;
        end
        check("str reach MEMWRITE", int'(State), 5);
        memw_cycles = 0;
        MemReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) MemReady = 1'b1;
            #1;
            if (MemW === 1'b1 && AdrSrc === 1'b1 && RegW === 1'b0) memw_cycles++;
            @(negedge clk);
        end
        check("str MemW stall cycles", memw_cycles, 5);
        #1;
        check("str return to FETCH", int'(State), 0);
        $display("seq str_stall: memw_cycles=%0d state=%0d", memw_cycles, State);

        // Hand sequence 2: reset in MEMREAD, RegW must never appear.
        @(negedge clk);
        Op = 2'b01; Funct = 6'b011001; MemReady = 1'b1;
        regw_seen = 0;
        cyc = 0;
        #1;
        while (State != 4'd3 && cyc < 10) begin
            if (RegW === 1'b1) regw_seen++;
            @(negedge clk); #1; cyc++;
        end
        check("ldr reach MEMREAD", int'(State), 3);
        reset = 1'b1;
        #1;
        check("strobes low in reset", int'({IRWrite, NextPC, RegW, MemW, Branch}), 0);
        @(negedge clk);
        reset = 1'b0; Op = 2'b11;
        #1;
        check("state after reset", int'(State), 0);
        for (int k = 0; k < 4; k++) begin
            if (RegW === 1'b1) regw_seen++;
            @(negedge clk); #1;
        end
        check("ldr RegW suppressed", regw_seen, 0);
        $display("seq ldr_reset: regw_seen=%0d", regw_seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
